// File: rtl/i2c_seg_target_pkg.sv
// Shared I2C definitions for the segment-display target: FSM states, R/W bit
// encoding and the display's default bus address.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic       I2C_WR        = 1'b0;
    localparam logic       I2C_RD        = 1'b1;
    localparam logic [6:0] I2C_DISP_ADDR = 7'h70;

    // True when an address byte selects this target for a write.
    function automatic logic addr_match(input logic [7:0] b, input logic [6:0] dev);
        return (b[7:1] == dev) && (b[0] == I2C_WR);
    endfunction

endpackage

// File: rtl/i2c_seg_target_if.sv
// Open-drain I2C bus pins as seen by the target: sampled SCL/SDA in,
// SDA pull-down enable out.
interface i2c_seg_target_if;
    logic scl_i;
    logic sda_in;
    logic sda_out_en;
    logic sda_out;

    modport slave  (input  scl_i, sda_in, output sda_out_en, sda_out);
    modport master (output scl_i, sda_in, input  sda_out_en, sda_out);
endinterface

// File: rtl/i2c_seg_target_line_sync.sv
// Synchronizer chain plus one edge-detect register for a single bus line.
// Resets to the idle-high bus level so no edge is seen coming out of reset.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  level_o & ~prev_q;
    assign fall_o  = ~level_o &  prev_q;
endmodule

// File: rtl/i2c_seg_target.sv
// Write-only I2C target: address match, register pointer byte, then data bytes
// presented as register writes with an auto-incrementing pointer.
module i2c_seg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = I2C_DISP_ADDR,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    i2c_seg_target_if.slave       bus,
    output logic                  reg_wr_o,
    output logic [PW-1:0]         reg_addr_o,
    output logic [7:0]            reg_data_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .line_i  (bus.scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .line_i  (bus.sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    i2c_state_e    state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          ack_q, ack_d;
    logic          wr_q, wr_d;
    logic [PW-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          got_data_q, got_data_d;

    // SCL must be steadily high (no SCL edge this cycle) for an SDA edge to
    // count as START/STOP; otherwise it is an ordinary data change.
    logic start_ev, stop_ev;
    assign start_ev = sda_fall & scl_lvl & ~scl_rise;
    assign stop_ev  = sda_rise & scl_lvl & ~scl_rise;

    logic       shifting, acking, byte_done, ack_end;
    logic [7:0] rx_byte;
    assign shifting  = (state_q == ADDR) || (state_q == PTR) || (state_q == DATA);
    assign acking    = (state_q == ADDR_ACK) || (state_q == PTR_ACK) || (state_q == DATA_ACK);
    assign rx_byte   = {shift_q[6:0], sda_lvl};
    assign byte_done = shifting & scl_rise & (bitcnt_q == 4'd7);
    assign ack_end   = acking & scl_fall & ack_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop_ev) begin
            state_d = IDLE;
        end else if (start_ev) begin
            state_d = ADDR;
        end else begin
            unique case (state_q)
                ADDR:     if (byte_done) state_d = addr_match(rx_byte, DEV_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (ack_end)   state_d = PTR;
                PTR:      if (byte_done) state_d = PTR_ACK;
                PTR_ACK:  if (ack_end)   state_d = DATA;
                DATA:     if (byte_done) state_d = DATA_ACK;
                DATA_ACK: if (ack_end)   state_d = DATA;
                default:  state_d = state_q;
            endcase
        end
    end

    // The ACK slot spans two SCL falls: the first after bit 8 pulls SDA low,
    // the one after the 9th clock releases it and moves on to the next byte.
    always_comb begin
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        ack_d      = ack_q;
        wr_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        got_data_d = got_data_q;
        if (stop_ev) begin
            bitcnt_d   = 4'd0;
            ack_d      = 1'b0;
            busy_d     = 1'b0;
            done_d     = got_data_q;
            got_data_d = 1'b0;
        end else if (start_ev) begin
            bitcnt_d   = 4'd0;
            ack_d      = 1'b0;
            busy_d     = 1'b0;
            got_data_d = 1'b0;
        end else begin
            if (shifting && scl_rise) begin
                shift_d  = rx_byte;
                bitcnt_d = bitcnt_q + 4'd1;
            end
            if (acking && scl_fall) begin
                ack_d = ~ack_q;
                if (ack_q) bitcnt_d = 4'd0;
            end
            if (byte_done) begin
                unique case (state_q)
                    ADDR: if (addr_match(rx_byte, DEV_ADDR)) busy_d = 1'b1;
                    PTR:  ptr_d = rx_byte[PW-1:0];
                    DATA: begin
                        wr_d       = 1'b1;
                        waddr_d    = ptr_q;
                        wdata_d    = rx_byte;
                        ptr_d      = ptr_q + 1'b1;
                        got_data_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bitcnt_q   <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            ack_q      <= 1'b0;
            wr_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            got_data_q <= 1'b0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            wr_q       <= wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            got_data_q <= got_data_d;
        end
    end

    assign bus.sda_out_en = ack_q;
    assign bus.sda_out    = 1'b0;
    assign reg_wr_o       = wr_q;
    assign reg_addr_o     = waddr_q;
    assign reg_data_o     = wdata_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;
endmodule

// File: tb/tb_i2c_seg_target.sv
// Bit-banged I2C master driving the target, with a frame-level reference model
// feeding write/frame-done scoreboards that a separate monitor drains.
module tb_i2c_seg_target;
    import i2c_pkg::*;

    localparam int Q = 6;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    i2c_seg_target_if bus();
    assign bus.scl_i  = m_scl;
    assign bus.sda_in = m_sda & ~(bus.sda_out_en & ~bus.sda_out);

    logic       reg_wr, busy, fdone;
    logic [3:0] reg_addr;
    logic [7:0] reg_data;

    i2c_seg_target #(.DEV_ADDR(7'h70), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .bus         (bus),
        .reg_wr_o    (reg_wr),
        .reg_addr_o  (reg_addr),
        .reg_data_o  (reg_data),
        .busy_o      (busy),
        .frame_done_o(fdone)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t  exp_wr[$];
    int   exp_done[$];
    wr_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_ptr = 0;
    int   frame_id = 0;
    logic [7:0] fb[8];
    logic ack;
    int   r, n;
    bit   st;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: drains the scoreboards whenever the DUT presents a write or frame end.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr %0d data %h expected none", reg_addr, reg_data);
                end else begin
                    mon_e = exp_wr.pop_front();
                    if (mon_e.a !== reg_addr || mon_e.d !== reg_data) begin
                        errors++;
                        $display("FAIL wr_value: got (%0d,%h) expected (%0d,%h)", reg_addr, reg_data, mon_e.a, mon_e.d);
                    end
                end
            end
            if (fdone) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL frame_done_unexpected: got pulse expected none");
                end else begin
                    void'(exp_done.pop_front());
                end
            end
        end
    end

    task automatic wait_clk(input int k);
        repeat (k) @(posedge clk);
    endtask

    task automatic bus_start;
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop;
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic bus_bit(input logic b);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(H);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H/2);
        #1 a = ~bus.sda_in;
        wait_clk(H/2);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic set_fb(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
    endtask

    // Reference model: a write frame is addr, pointer, data...; only a write to
    // 0x70 is acknowledged, data lands at pointer++ mod 16, and a STOP after at
    // least one data byte closes the frame.
    task automatic run_frame(input int nb, input bit end_stop);
        logic a;
        bit   hit;
        hit = (nb > 0) && (fb[0][7:1] == 7'h70) && (fb[0][0] == I2C_WR);
        bus_start;
        chk("busy_after_start", busy, 0);
        for (int i = 0; i < nb; i++) begin
            if (hit && i == 1) begin
                m_ptr = fb[1] % 16;
            end else if (hit && i >= 2) begin
                exp_wr.push_back({m_ptr[3:0], fb[i]});
                m_ptr = (m_ptr + 1) % 16;
            end
            bus_byte(fb[i], a);
            chk($sformatf("ack_f%0d_b%0d", frame_id, i), a, hit);
            chk($sformatf("busy_f%0d_b%0d", frame_id, i), busy, hit);
        end
        if (end_stop) begin
            if (hit && nb >= 3) exp_done.push_back(frame_id);
            bus_stop;
            wait_clk(4);
            chk("busy_after_stop", busy, 0);
        end
        frame_id++;
    endtask

    initial begin
        wait_clk(5);
        #1;
        chk("rst_sda_out_en", bus.sda_out_en, 0);
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", fdone, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_data", reg_data, 0);
        rst_n = 1'b1;
        wait_clk(10);

        // Basic write: two bytes at pointer 0.
        set_fb(8'hE0, 8'h00, 8'h12, 8'h34); run_frame(4, 1);
        // Foreign address 0x71 with data.
        set_fb(8'hE2, 8'h00, 8'h11, 8'h22); run_frame(4, 1);
        // Read request is ignored, then a normal write still works.
        set_fb(8'hE1, 8'h00, 8'h00, 8'h00); run_frame(1, 1);
        set_fb(8'hE0, 8'h05, 8'h9C, 8'h00); run_frame(3, 1);
        // Pointer wrap 15 -> 0, then a pointer-only frame.
        set_fb(8'hE0, 8'h0F, 8'hAA, 8'hBB); run_frame(4, 1);
        set_fb(8'hE0, 8'h03, 8'h00, 8'h00); run_frame(2, 1);
        // Repeated START after 5 bits of a data byte.
        set_fb(8'hE0, 8'h07, 8'h00, 8'h00); run_frame(2, 0);
        for (int i = 0; i < 5; i++) bus_bit(i[0]);
        set_fb(8'hE0, 8'h02, 8'h55, 8'h00); run_frame(3, 1);

        // Reset pulsed during the ACK of a data byte.
        set_fb(8'hE0, 8'h05, 8'h00, 8'h00); run_frame(2, 0);
        exp_wr.push_back({4'd5, 8'h77});
        for (int i = 7; i >= 0; i--) bus_bit(((8'h77 >> i) & 8'h01) != 0);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(2);
        #1 chk("ack_before_reset", bus.sda_out_en, 1);
        #2 rst_n = 1'b0;
        #1 chk("sda_released_async", bus.sda_out_en, 0);
        chk("busy_in_reset", busy, 0);
        m_ptr = 0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(H);
        m_scl = 1'b0; wait_clk(Q);
        bus_byte(8'hE0, ack); chk("post_reset_ack_addr", ack, 0);
        bus_byte(8'h01, ack); chk("post_reset_ack_ptr", ack, 0);
        bus_byte(8'h66, ack); chk("post_reset_ack_data", ack, 0);
        chk("post_reset_busy", busy, 0);
        bus_stop;
        wait_clk(10);

        // Randomized frames; non-STOP endings chain into a repeated START.
        for (int f = 0; f < 14; f++) begin
            r  = $urandom_range(0, 3);
            n  = $urandom_range(0, 5);
            st = (f == 13) || ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 8; i++) fb[i] = 8'($urandom_range(0, 255));
            if (r < 2)       fb[0] = 8'hE0;
            else if (r == 2) fb[0] = 8'hE1;
            run_frame(n, st);
        end

        wait_clk(50);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
